// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with valid/ready handshake, optional 1-entry skid and flush.
// Latency 1 cycle; with SKID_EN=1 in_ready_o is registered and a second entry is absorbed on stall.
module pipe_stage_latch #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [ADDR_W-1:0] in_waddr_i,
  input  logic              in_wen_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_waddr_o,
  output logic              out_wen_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] waddr;
    logic              wen;
  } entry_t;

  entry_t            main_q;
  entry_t            skid_q;
  entry_t            in_ent;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              drain;
  logic [CNT_W-1:0]  bp_cnt;

  assign in_ent = '{data: in_data_i, waddr: in_waddr_i, wen: in_wen_i};

  // Skid mode: ready depends only on skid occupancy, so it comes straight from a flop.
  assign in_ready_o = SKID_EN ? !skid_valid : (!main_valid || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign drain      = main_valid && out_ready_i;

  assign out_valid_o = main_valid;
  assign out_data_o  = main_q.data;
  assign out_waddr_o = main_q.waddr;
  assign out_wen_o   = main_q.wen;
  assign bp_cnt_o    = bp_cnt;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      bp_cnt     <= '0;
    end else begin
      if (main_valid && !out_ready_i && (bp_cnt != {CNT_W{1'b1}}))
        bp_cnt <= bp_cnt + 1'b1;

      // wen is cleared alongside valid so out_wen_o never asserts on an empty slot.
      if (flush_i) begin
        main_valid  <= 1'b0;
        main_q.wen  <= 1'b0;
        skid_valid  <= 1'b0;
        skid_q.wen  <= 1'b0;
      end else if (SKID_EN) begin
        if (skid_valid) begin
          if (drain) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
            skid_q.wen <= 1'b0;
          end
        end else if (main_valid) begin
          if (accept && drain) begin
            main_q <= in_ent;
          end else if (accept) begin
            skid_q     <= in_ent;
            skid_valid <= 1'b1;
          end else if (drain) begin
            main_valid <= 1'b0;
            main_q.wen <= 1'b0;
          end
        end else if (accept) begin
          main_q     <= in_ent;
          main_valid <= 1'b1;
        end
      end else begin
        if (accept) begin
          main_q     <= in_ent;
          main_valid <= 1'b1;
        end else if (drain) begin
          main_valid <= 1'b0;
          main_q.wen <= 1'b0;
        end
      end
    end
  end

endmodule
